// File: rtl/set_assoc_cache.sv
// set_assoc_cache: 2-way set-associative write-back cache with LRU replacement and word-serial memory refill.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module set_assoc_cache #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 10,
  parameter int INDEX_W  = 4,
  parameter int OFFSET_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 2 ** INDEX_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, ALLOCATE} state_t;
  state_t state, state_nx;

  logic [ADDR_W-1:0]         req_addr;
  logic                      req_rw;
  logic [DATA_W-1:0]         req_wdata;
  logic [OFFSET_W-1:0]       cnt;
  logic                      victim;
  logic [1:0][SETS-1:0]      valid;
  logic [1:0][SETS-1:0]      dirty;
  logic [SETS-1:0]           lru;
  logic [TAG_W-1:0]          tags [2][SETS];
  logic [DATA_W-1:0]         data [2][SETS*(2**OFFSET_W)];

  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;
  logic hit0, hit1, hit, hway, vway, last, accept, xfer;

  assign tag    = req_addr[ADDR_W-1 -: TAG_W];
  assign idx    = req_addr[OFFSET_W +: INDEX_W];
  assign off    = req_addr[OFFSET_W-1:0];
  assign hit0   = valid[0][idx] && tags[0][idx] == tag;
  assign hit1   = valid[1][idx] && tags[1][idx] == tag;
  assign hit    = hit0 || hit1;
  assign hway   = !hit0;
  assign vway   = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
  assign last   = &cnt;
  assign accept = cpu_req_valid && cpu_req_ready;
  assign xfer   = (state == WRITEBACK || state == ALLOCATE) && mem_ready;

  assign cpu_req_ready  = state == IDLE && !rst;
  assign cpu_resp_valid = state == LOOKUP && hit;
  assign cpu_rdata      = cpu_resp_valid ? (req_rw ? req_wdata : data[hway][{idx, off}]) : '0;
  assign mem_req        = state == WRITEBACK || state == ALLOCATE;
  assign mem_rw         = state == WRITEBACK;
  assign mem_addr       = state == WRITEBACK ? {tags[victim][idx], idx, cnt} :
                          state == ALLOCATE  ? {tag, idx, cnt} : '0;
  assign mem_wdata      = state == WRITEBACK ? data[victim][{idx, cnt}] : '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = cpu_req_valid ? LOOKUP : IDLE;
      LOOKUP:    state_nx = hit ? IDLE : (valid[vway][idx] && dirty[vway][idx]) ? WRITEBACK : ALLOCATE;
      WRITEBACK: state_nx = mem_ready && last ? ALLOCATE : WRITEBACK;
      ALLOCATE:  state_nx = mem_ready && last ? LOOKUP : ALLOCATE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      victim    <= 1'b0;
      req_addr  <= '0;
      req_rw    <= 1'b0;
      req_wdata <= '0;
      valid     <= '0;
      dirty     <= '0;
      lru       <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_addr  <= cpu_addr;
        req_rw    <= cpu_rw;
        req_wdata <= cpu_wdata;
      end
      if (state == LOOKUP && hit) begin
        lru[idx] <= !hway;
        if (req_rw) dirty[hway][idx] <= 1'b1;
      end
      if (state == LOOKUP && !hit) victim <= vway;
      // cnt wraps to zero after the last word, ready for the next phase
      if (xfer) cnt <= cnt + OFFSET_W'(1);
      if (state == ALLOCATE && mem_ready && last) begin
        valid[victim][idx] <= 1'b1;
        dirty[victim][idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && req_rw) data[hway][{idx, off}] <= req_wdata;
    if (state == ALLOCATE && mem_ready) data[victim][{idx, cnt}] <= mem_rdata;
    if (state == ALLOCATE && mem_ready && last) tags[victim][idx] <= tag;
  end

`ifdef CACHE_STATS_EN
  logic first;

  // only the first LOOKUP of a request is counted; the post-fill re-lookup is not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first      <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      first <= accept ? 1'b1 : state == LOOKUP ? 1'b0 : first;
      if (state == LOOKUP && first && hit) hit_count <= hit_count + {31'd0, ~&hit_count};
      if (state == LOOKUP && first && !hit) miss_count <= miss_count + {31'd0, ~&miss_count};
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule
